// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: steers serialized samples into slots 0..3 and
// presents each complete frame on y0..y3 with a valid/ready handshake.
// Optional sticky overrun flag is built when TDM_DEMUX_OVERRUN_EN is defined.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | unaligned; waits for a sync sample to start filling slot 0
// RUN   | aligned; sel is the slot the next valid sample is written to
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  input  logic             frame_ready
`ifdef TDM_DEMUX_OVERRUN_EN
  ,
  output logic             overrun
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sh0, sh1, sh2;
  logic             start, wr_run, complete;
  logic [1:0]       sel_next;
  logic             fv_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == IDLE && din_valid && sync) state_next = RUN;
  end

  // A sync sample restarts the frame unless it lands exactly on slot 0 in RUN,
  // where it is just an ordinary slot-0 write.
  always_comb begin
    start    = din_valid && sync && (state == IDLE || sel != 2'd0);
    wr_run   = (state == RUN) && din_valid && !start;
    complete = wr_run && (sel == 2'd3);
    sel_next = sel;
    if (start)       sel_next = 2'd1;
    else if (wr_run) sel_next = sel + 2'd1;
    fv_next = frame_valid;
    if (complete)                        fv_next = 1'b1;
    else if (frame_valid && frame_ready) fv_next = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel         <= 2'd0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      y0          <= '0;
      y1          <= '0;
      y2          <= '0;
      y3          <= '0;
      frame_valid <= 1'b0;
    end else begin
      sel         <= sel_next;
      frame_valid <= fv_next;
      if (start || (wr_run && sel == 2'd0)) sh0 <= din;
      if (wr_run && sel == 2'd1)            sh1 <= din;
      if (wr_run && sel == 2'd2)            sh2 <= din;
      // Slot 3 bypasses the shadow so the frame is visible one clock after its last sample.
      if (complete) begin
        y0 <= sh0;
        y1 <= sh1;
        y2 <= sh2;
        y3 <= din;
      end
    end
  end

`ifdef TDM_DEMUX_OVERRUN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        overrun <= 1'b0;
    else if (complete && frame_valid && !frame_ready) overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: expected frames are queued when their final
// sample is driven and popped/compared one clock later.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid, sync, frame_ready;
  logic [1:0] sel;
  logic [7:0] y0, y1, y2, y3;
  logic       frame_valid;
  logic       overrun;
  logic       exp_ovr;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] held_y;

  always #5 clk = ~clk;

`ifndef TDM_DEMUX_OVERRUN_EN
  assign overrun = 1'b0;
`endif

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .sel(sel), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .frame_valid(frame_valid), .frame_ready(frame_ready)
`ifdef TDM_DEMUX_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_y(input string tag, input logic [31:0] exp);
    chk({tag, ".y0"}, {24'd0, y0}, {24'd0, exp[7:0]});
    chk({tag, ".y1"}, {24'd0, y1}, {24'd0, exp[15:8]});
    chk({tag, ".y2"}, {24'd0, y2}, {24'd0, exp[23:16]});
    chk({tag, ".y3"}, {24'd0, y3}, {24'd0, exp[31:24]});
  endtask

  task automatic push_frame(input logic [7:0] a, b, c, d);
    exp_q.push_back({d, c, b, a});
  endtask

  // One clock: drive inputs, take the edge, check 1 time unit later.
  task automatic step(input string tag, input logic [7:0] d, input logic v, s, r,
                      input logic [1:0] esel, input logic efv, input bit done);
    din = d; din_valid = v; sync = s; frame_ready = r;
    @(posedge clk);
    #1;
    chk({tag, ".sel"}, {30'd0, sel}, {30'd0, esel});
    chk({tag, ".fv"}, {31'd0, frame_valid}, {31'd0, efv});
`ifdef TDM_DEMUX_OVERRUN_EN
    chk({tag, ".ovr"}, {31'd0, overrun}, {31'd0, exp_ovr});
`endif
    if (done) begin
      if (exp_q.size() == 0) chk({tag, ".q_empty"}, 32'd1, 32'd0);
      else held_y = exp_q.pop_front();
    end
    chk_y(tag, held_y);
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; sync = 1'b0; frame_ready = 1'b0;
    held_y = '0; exp_ovr = 1'b0;
    #2;
    chk("rst.sel", {30'd0, sel}, 32'd0);
    chk("rst.fv", {31'd0, frame_valid}, 32'd0);
    chk("rst.ovr", {31'd0, overrun}, 32'd0);
    chk_y("rst", 32'd0);
    #11 rst = 1'b0;

    // Unaligned samples are dropped
    step("idle0", 8'h11, 1, 0, 1, 2'd0, 0, 0);
    step("idle1", 8'h22, 1, 0, 1, 2'd0, 0, 0);

    // Basic frame, frame_valid for exactly one cycle
    step("a0", 8'hA0, 1, 1, 1, 2'd1, 0, 0);
    step("a1", 8'hA1, 1, 0, 1, 2'd2, 0, 0);
    step("a2", 8'hA2, 1, 0, 1, 2'd3, 0, 0);
    push_frame(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    step("a3", 8'hA3, 1, 0, 1, 2'd0, 1, 1);
    step("a_gap", 8'h00, 0, 0, 1, 2'd0, 0, 0);

    // Back-to-back frames
    step("s0", 8'h00, 1, 1, 1, 2'd1, 0, 0);
    step("s1", 8'h01, 1, 0, 1, 2'd2, 0, 0);
    step("s2", 8'h02, 1, 0, 1, 2'd3, 0, 0);
    push_frame(8'h00, 8'h01, 8'h02, 8'h03);
    step("s3", 8'h03, 1, 0, 1, 2'd0, 1, 1);
    step("s4", 8'h04, 1, 1, 1, 2'd1, 0, 0);
    step("s5", 8'h05, 1, 0, 1, 2'd2, 0, 0);
    step("s6", 8'h06, 1, 0, 1, 2'd3, 0, 0);
    push_frame(8'h04, 8'h05, 8'h06, 8'h07);
    step("s7", 8'h07, 1, 0, 1, 2'd0, 1, 1);
    // Held frame accepted on the same edge a new one completes: valid stays high
    step("s8", 8'h08, 1, 1, 0, 2'd1, 1, 0);
    step("s9", 8'h09, 1, 0, 0, 2'd2, 1, 0);
    step("sA", 8'h0A, 1, 0, 0, 2'd3, 1, 0);
    push_frame(8'h08, 8'h09, 8'h0A, 8'h0B);
    step("sB", 8'h0B, 1, 0, 1, 2'd0, 1, 1);
    step("s_acc", 8'h00, 0, 0, 1, 2'd0, 0, 0);

    // Resync discards a partial frame; bare sync is ignored
    step("r10", 8'h10, 1, 1, 1, 2'd1, 0, 0);
    step("r11", 8'h11, 1, 0, 1, 2'd2, 0, 0);
    step("rns", 8'h55, 0, 1, 1, 2'd2, 0, 0);
    step("r20", 8'h20, 1, 1, 1, 2'd1, 0, 0);
    step("r21", 8'h21, 1, 0, 1, 2'd2, 0, 0);
    step("r22", 8'h22, 1, 0, 1, 2'd3, 0, 0);
    push_frame(8'h20, 8'h21, 8'h22, 8'h23);
    step("r23", 8'h23, 1, 0, 1, 2'd0, 1, 1);
    step("r_acc", 8'h00, 0, 0, 1, 2'd0, 0, 0);

    // Overwrite while consumer stalls
    step("b0", 8'hB0, 1, 1, 0, 2'd1, 0, 0);
    step("b1", 8'hB1, 1, 0, 0, 2'd2, 0, 0);
    step("b2", 8'hB2, 1, 0, 0, 2'd3, 0, 0);
    push_frame(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    step("b3", 8'hB3, 1, 0, 0, 2'd0, 1, 1);
    step("c0", 8'hC0, 1, 1, 0, 2'd1, 1, 0);
    step("c1", 8'hC1, 1, 0, 0, 2'd2, 1, 0);
    step("c2", 8'hC2, 1, 0, 0, 2'd3, 1, 0);
    push_frame(8'hC0, 8'hC1, 8'hC2, 8'hC3);
    exp_ovr = 1'b1;
    step("c3", 8'hC3, 1, 0, 0, 2'd0, 1, 1);
    step("c_hold", 8'h00, 0, 0, 0, 2'd0, 1, 0);
    step("c_acc", 8'h00, 0, 0, 1, 2'd0, 0, 0);

    // Async reset mid-frame, off the clock edge
    step("d0", 8'hD0, 1, 1, 1, 2'd1, 0, 0);
    step("d1", 8'hD1, 1, 0, 1, 2'd2, 0, 0);
    #3 rst = 1'b1;
    #1;
    held_y = '0; exp_ovr = 1'b0;
    chk("arst.sel", {30'd0, sel}, 32'd0);
    chk("arst.fv", {31'd0, frame_valid}, 32'd0);
    chk("arst.ovr", {31'd0, overrun}, 32'd0);
    chk_y("arst", 32'd0);
    #3 rst = 1'b0;
    step("e_drop", 8'hE1, 1, 0, 1, 2'd0, 0, 0);
    step("e0", 8'h40, 1, 1, 1, 2'd1, 0, 0);
    step("e1", 8'h41, 1, 0, 1, 2'd2, 0, 0);
    step("e2", 8'h42, 1, 0, 1, 2'd3, 0, 0);
    push_frame(8'h40, 8'h41, 8'h42, 8'h43);
    step("e3", 8'h43, 1, 0, 1, 2'd0, 1, 1);

    chk("q_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
